// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder constants, unload FSM state type and padding-mask helper.
package ldpc_pkg;

  localparam int unsigned Kb           = 14;
  localparam int unsigned HDWIDTH      = 32;
  localparam int unsigned LINES        = 16;
  localparam int unsigned Z            = 511;
  localparam int unsigned ADDRESSWIDTH = 5;
  localparam int unsigned RD_LAT       = 2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    SHIFT,
    DRAIN
  } unload_state_t;

  // Bit b of a column in line 'line' is real data only while line*HDWIDTH+b < Z.
  function automatic logic [HDWIDTH-1:0] pad_mask(input int unsigned line);
    logic [HDWIDTH-1:0] m;
    m = '0;
    for (int unsigned b = 0; b < HDWIDTH; b++) begin
      m[b] = ((line * HDWIDTH) + b) < Z;
    end
    return m;
  endfunction

endpackage

// File: rtl/hd_word_shifter.sv
// Holds one hard-decision line and presents it one column at a time, column 0 first.
module hd_word_shifter #(
  parameter int unsigned COLS = 14,
  parameter int unsigned W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [COLS*W-1:0] line_in,
  output logic [W-1:0]      word
);

  logic [COLS*W-1:0] line_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q <= '0;
    end else if (load) begin
      line_q <= line_in;
    end else if (shift) begin
      line_q <= {{W{1'b0}}, line_q[COLS*W-1:W]};
    end
  end

  assign word = line_q[W-1:0];

endmodule

// File: rtl/hd_unload_streamer.sv
// Lmem unload reader: fetches LINES hard-decision lines and streams them as HDWIDTH-bit words.
// Build option HD_UNLOAD_PREFETCH_EN adds a ping-pong line buffer so fetch overlaps streaming.
module hd_unload_streamer
  import ldpc_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    unload_en,
  output logic [ADDRESSWIDTH-1:0] unloadAddress,
  input  logic [Kb*HDWIDTH-1:0]   unload_HDout_vec,
  output logic [HDWIDTH-1:0]      out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last
);

  localparam int unsigned COL_W  = (Kb > 1) ? $clog2(Kb) : 1;
  localparam int unsigned WAIT_W = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
  localparam logic [ADDRESSWIDTH-1:0] LAST_LINE = ADDRESSWIDTH'(LINES - 1);
  localparam logic [COL_W-1:0]        LAST_COL  = COL_W'(Kb - 1);
  localparam logic [HDWIDTH-1:0]      LAST_MASK = pad_mask(LINES - 1);

  unload_state_t             state_q, state_d;
  logic [ADDRESSWIDTH-1:0]   addr_q, addr_d;
  logic [COL_W-1:0]          col_q, col_d;
  logic [WAIT_W-1:0]         wait_q, wait_d;
  logic                      handshake;

  assign handshake     = out_valid & out_ready;
  assign unloadAddress = addr_q;
  assign busy          = (state_q != IDLE) && (state_q != DRAIN);
  assign done          = (state_q == DRAIN);

`ifdef HD_UNLOAD_PREFETCH_EN

  // addr_q is the fetch pointer; out_line_q tracks the line being streamed.
  logic [1:0]              full_q, full_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [ADDRESSWIDTH-1:0] out_line_q, out_line_d;
  logic [1:0]              load, shift;
  logic [HDWIDTH-1:0]      word0, word1, raw_word;

  hd_word_shifter #(.COLS(Kb), .W(HDWIDTH)) u_shifter0 (
    .clk     (clk),
    .rst     (rst),
    .load    (load[0]),
    .shift   (shift[0]),
    .line_in (unload_HDout_vec),
    .word    (word0)
  );

  hd_word_shifter #(.COLS(Kb), .W(HDWIDTH)) u_shifter1 (
    .clk     (clk),
    .rst     (rst),
    .load    (load[1]),
    .shift   (shift[1]),
    .line_in (unload_HDout_vec),
    .word    (word1)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      col_q      <= '0;
      wait_q     <= '0;
      full_q     <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      out_line_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      col_q      <= col_d;
      wait_q     <= wait_d;
      full_q     <= full_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      out_line_q <= out_line_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    col_d      = col_q;
    wait_d     = wait_q;
    full_d     = full_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    out_line_d = out_line_q;
    load       = '0;
    shift      = '0;

    // Emit side: only ever clears the buffer at rd_ptr; fetch side only fills an empty one.
    if (handshake) begin
      if (col_q == LAST_COL) begin
        col_d            = '0;
        full_d[rd_ptr_q] = 1'b0;
        rd_ptr_d         = ~rd_ptr_q;
        out_line_d       = out_line_q + 1'b1;
      end else begin
        col_d           = col_q + 1'b1;
        shift[rd_ptr_q] = 1'b1;
      end
    end

    case (state_q)
      IDLE, DRAIN: begin
        if (start) begin
          state_d    = ISSUE;
          addr_d     = '0;
          col_d      = '0;
          full_d     = '0;
          wr_ptr_d   = 1'b0;
          rd_ptr_d   = 1'b0;
          out_line_d = '0;
        end else if (state_q == DRAIN) begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (!full_q[wr_ptr_q]) begin
          wait_d  = '0;
          state_d = (RD_LAT > 1) ? WAIT : CAPTURE;
        end
      end
      WAIT: begin
        if (wait_q == WAIT_W'(RD_LAT - 2)) state_d = CAPTURE;
        else                               wait_d  = wait_q + 1'b1;
      end
      CAPTURE: begin
        load[wr_ptr_q]   = 1'b1;
        full_d[wr_ptr_q] = 1'b1;
        wr_ptr_d         = ~wr_ptr_q;
        if (addr_q == LAST_LINE) begin
          state_d = SHIFT;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ISSUE;
        end
      end
      SHIFT: begin
        if (handshake && (col_q == LAST_COL) && (out_line_q == LAST_LINE)) state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end

  assign unload_en = (state_q == ISSUE) && !full_q[wr_ptr_q];
  assign out_valid = full_q[rd_ptr_q];
  assign raw_word  = rd_ptr_q ? word1 : word0;
  assign out_data  = raw_word & ((out_line_q == LAST_LINE) ? LAST_MASK : '1);
  assign out_last  = out_valid && (out_line_q == LAST_LINE) && (col_q == LAST_COL);

`else

  logic               load, shift;
  logic [HDWIDTH-1:0] raw_word;

  hd_word_shifter #(.COLS(Kb), .W(HDWIDTH)) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .shift   (shift),
    .line_in (unload_HDout_vec),
    .word    (raw_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      col_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    col_d   = col_q;
    wait_d  = wait_q;
    load    = 1'b0;
    shift   = 1'b0;

    case (state_q)
      IDLE, DRAIN: begin
        if (start) begin
          state_d = ISSUE;
          addr_d  = '0;
          col_d   = '0;
        end else if (state_q == DRAIN) begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        wait_d  = '0;
        state_d = (RD_LAT > 1) ? WAIT : CAPTURE;
      end
      WAIT: begin
        if (wait_q == WAIT_W'(RD_LAT - 2)) state_d = CAPTURE;
        else                               wait_d  = wait_q + 1'b1;
      end
      CAPTURE: begin
        load    = 1'b1;
        col_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (out_ready) begin
          if (col_q == LAST_COL) begin
            if (addr_q == LAST_LINE) begin
              state_d = DRAIN;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = ISSUE;
            end
          end else begin
            col_d = col_q + 1'b1;
            shift = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign unload_en = (state_q == ISSUE);
  assign out_valid = (state_q == SHIFT);
  assign out_data  = raw_word & ((addr_q == LAST_LINE) ? LAST_MASK : '1);
  assign out_last  = out_valid && (addr_q == LAST_LINE) && (col_q == LAST_COL);

`endif

endmodule

// File: tb/tb_hd_unload_streamer.sv
// Scoreboard bench for hd_unload_streamer with a 2-cycle Lmem model and random backpressure.
module tb_hd_unload_streamer;

  localparam int KB = 14;
  localparam int HW = 32;
  localparam int NL = 16;
  localparam int ZZ = 511;
  localparam int NW = KB * NL;
`ifdef HD_UNLOAD_PREFETCH_EN
  localparam int EXP_SPAN = NW;
`else
  localparam int EXP_SPAN = NW + (NL - 1) * 3;
`endif

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 unload_en;
  logic [4:0]           unloadAddress;
  logic [KB*HW-1:0]     unload_HDout_vec;
  logic [HW-1:0]        out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;

  hd_unload_streamer dut (
    .clk              (clk),
    .rst              (rst_n),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .unload_en        (unload_en),
    .unloadAddress    (unloadAddress),
    .unload_HDout_vec (unload_HDout_vec),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_last         (out_last)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  int          hs_cyc[$];
  int          addr_log[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          hs_total = 0;
  int          ue_total = 0;
  int          done_total = 0;
  int          mem_mode = 0;
  bit          bp_en = 0;
  int          b_hs, b_ue, b_done;

  logic        prev_stall = 0;
  logic        prev_last_hs = 0;
  logic [31:0] prev_data = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: column k of line a is {a, k, A5A5} (or all ones), with bits at a*32+b >= Z zeroed.
  function automatic logic [31:0] model_word(input int line, input int k, input int mode);
    logic [31:0] w;
    logic [7:0]  l8, k8;
    l8 = 8'(line);
    k8 = 8'(k);
    w  = (mode != 0) ? 32'hFFFF_FFFF : {l8, k8, 16'hA5A5};
    for (int b = 0; b < 32; b++)
      if (line * HW + b >= ZZ) w[b] = 1'b0;
    return w;
  endfunction

  function automatic logic [KB*HW-1:0] mem_line(input logic [4:0] a, input int mode);
    logic [KB*HW-1:0] v;
    logic [7:0]       k8;
    for (int k = 0; k < KB; k++) begin
      k8 = 8'(k);
      v[k*HW +: HW] = (mode != 0) ? 32'hFFFF_FFFF : {3'b000, a, k8, 16'hA5A5};
    end
    return v;
  endfunction

  // Lmem model: address registered on the strobe, data registered one cycle later.
  logic       en1;
  logic [4:0] a1;
  initial unload_HDout_vec = '0;
  always @(posedge clk) begin
    en1 <= unload_en;
    a1  <= unloadAddress;
    if (en1) unload_HDout_vec <= mem_line(a1, mem_mode);
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall   = 1'b0;
      prev_last_hs = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", out_data, prev_data);
      end
      if (done) begin
        done_total++;
        chk("done_after_last", 32'(prev_last_hs), 32'd1);
        chk("busy_low_at_done", 32'(busy), 32'd0);
      end
      if (unload_en) begin
        ue_total++;
        addr_log.push_back(int'(unloadAddress));
      end
      if (out_valid && out_ready) begin
        hs_cyc.push_back(cyc);
        hs_total++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_word actual=%h required=none", out_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("word_data", out_data, e.data);
          chk("word_last", 32'(out_last), 32'(e.last));
        end
      end
      prev_stall   = out_valid && !out_ready;
      prev_data    = out_data;
      prev_last_hs = out_valid && out_ready && out_last;
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic push_expected(input int mode);
    exp_t e;
    for (int l = 0; l < NL; l++)
      for (int k = 0; k < KB; k++) begin
        e.data = model_word(l, k, mode);
        e.last = (l == NL - 1) && (k == KB - 1);
        exp_q.push_back(e);
      end
  endtask

  task automatic wait_words(input int n);
    int t = 0;
    while ((hs_total - b_hs) < n && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 4000) begin
      checks++;
      failures++;
      $display("FAIL word_wait_timeout actual=%0d required=%0d", hs_total - b_hs, n);
    end
  endtask

  task automatic run_stream(input int mode, input bit bp, input bit mid_start, input bit span_chk);
    int t;
    b_hs   = hs_total;
    b_ue   = ue_total;
    b_done = done_total;
    addr_log.delete();
    mem_mode = mode;
    bp_en    = bp;
    push_expected(mode);
    pulse_start();
    if (mid_start) begin
      wait_words(50);
      pulse_start();
    end
    t = 0;
    while (done_total == b_done && t < 6000) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    bp_en = 1'b0;
    chk("done_pulses", 32'(done_total - b_done), 32'd1);
    chk("word_count", 32'(hs_total - b_hs), 32'(NW));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("unload_count", 32'(ue_total - b_ue), 32'(NL));
    for (int i = 0; i < addr_log.size() && i < NL; i++)
      chk("addr_seq", 32'(addr_log[i]), 32'(i));
    if (span_chk) begin
      if (hs_cyc.size() >= b_hs + NW)
        chk("stream_span", 32'(hs_cyc[b_hs + NW - 1] - hs_cyc[b_hs] + 1), 32'(EXP_SPAN));
      else begin
        checks++;
        failures++;
        $display("FAIL stream_span actual=short required=%0d", EXP_SPAN);
      end
    end
    exp_q.delete();
  endtask

  task automatic check_idle_outputs();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_unload_en", 32'(unload_en), 32'd0);
    chk("rst_addr", 32'(unloadAddress), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
  endtask

  initial begin
    start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 check_idle_outputs();
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_stream(0, 1'b0, 1'b0, 1'b1);
    run_stream(0, 1'b1, 1'b0, 1'b0);
    run_stream(1, 1'b0, 1'b0, 1'b1);
    run_stream(1, 1'b1, 1'b0, 1'b0);
    run_stream(0, 1'b0, 1'b1, 1'b0);

    b_hs     = hs_total;
    mem_mode = 0;
    push_expected(0);
    pulse_start();
    wait_words(100);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs();
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_stream(0, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
